aes_decrypt: RTL and testbench
==============================

# aes_decrypt

Iterative AES inverse cipher, the decryption counterpart of the existing encryption datapath. It takes one 128-bit ciphertext block and an N-bit cipher key, runs one inverse round per clock, and returns the 128-bit plaintext with a valid/ready handshake on both sides. It reuses `KeyExpansion #(N,Nr,Nk)`, and its packed round-key bus ordering is unchanged: round key i sits at `keys[128*(Nr-i) +: 128]`. It sits beside the encryptor in the AES top level.

## Interface
- `N`, default 128: key width; legal values are 128, 192 and 256.
- `Nr`, default 10: number of rounds; 10, 12 or 14 respectively.
- `Nk`, default 4: key words; 4, 6 or 8 respectively.
- `clk`  in  1  rising-edge clock; this is the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `datain`/`key` are valid.
- `in_ready`  out  1  block can accept a new job.
- `datain`  in  128  ciphertext block; byte 0 is in bits [127:120].
- `key`  in  N  cipher key, FIPS-197 byte order.
- `out_valid`  out  1  `dataout` holds a finished plaintext.
- `out_ready`  in  1  consumer accepts `dataout`.
- `dataout`  out  128  plaintext block.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: register `datain` into `ct_reg` and `key` into `key_reg`, then go to LOAD.
  - `KeyExpansion` is driven only from `key_reg`, so the round keys stay stable for the whole job.
- LOAD: `st <= ct_reg ^ rk[Nr]`, `rnd <= Nr-1`, go to ROUND.
- ROUND:
  - `st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[rnd])`.
  - If `rnd==1`, go to FINAL; otherwise `rnd <= rnd-1`.
- FINAL:
  - `dataout <= InvSubBytes(InvShiftRows(st)) ^ rk[0]`.
  - `out_valid <= 1`, go to DONE.
- DONE:
  - Hold `dataout` and `out_valid`.
  - On `out_ready`: `out_valid <= 0`, go to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap of jobs.
- `rnd` is 4 bits wide, enough for Nr up to 14. It never wraps below 1.
- Inverse transforms per FIPS-197 §5.3:
  - InvShiftRows rotates row r right by r bytes.
  - InvSubBytes uses the inverse S-box.
  - InvMixColumns uses the {0e,0b,0d,09} matrix over GF(2^8) with reduction polynomial 0x11b.
- `datain` and `key` are ignored outside an accepting IDLE cycle. Changes during a job have no effect.
- `out_ready` is ignored outside DONE.

## Timing
- Acceptance edge = T0. LOAD edge = T1. ROUND edges = T2..T(Nr).
- FINAL edge = T(Nr+1); `out_valid` rises after this edge.
- Latency from acceptance to `out_valid` is Nr+1 cycles: 11, 13 or 15.
- `in_ready` falls after T0. It rises again on the edge where `out_valid && out_ready` completes.
- Earliest next acceptance is the following cycle, which gives throughput of one block per Nr+3 cycles with `out_ready` tied high.
- `out_valid` stays asserted until `out_ready`, with `dataout` stable throughout.
- Reset value of every output and register, applied immediately on `reset` assertion independent of `clk`:
  - `in_ready`=1 (combinational from IDLE); `out_valid`=0; `dataout`=0.
  - `st`, `ct_reg`, `key_reg` and `rnd` = 0.
  - FSM = IDLE.
- Reset mid-operation aborts the job; `out_valid` is not asserted for the aborted block. The first edge after deassertion behaves as IDLE.
- `out_valid && out_ready` together with `in_valid` in the same DONE cycle: the output is retired only. The new job is accepted in the next cycle, while in IDLE.

## Test plan
- AES-128, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, datain 3925841d02dc09fbdc118597196a0b32 -> `dataout`=3243f6a8885a308d313198a2e0370734, `out_valid` exactly 11 cycles after acceptance.
- AES-128/192/256, FIPS-197 App. C. Key is 000102… of the matching length; each ciphertext must decrypt to 00112233445566778899aabbccddeeff, with latency 11, 13 and 15 respectively:
  - AES-128 datain 69c4e0d86a7b0430d8cdb78070b4c55a.
  - AES-192 datain dda97ca4864cdfe06eaf70a0ec0d7191.
  - AES-256 datain 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` -> `dataout` and `out_valid` stay stable, `in_ready` stays 0, and `in_valid` pulses are ignored. Raising `out_ready` retires the output; `in_ready` is 1 on the next cycle.
- Input stability: change `datain`/`key` to random values every cycle during a job -> the App. B result is still correct.
- Reset mid-job: assert `reset` at cycle 5 of an App. B job -> `out_valid`=0 and `dataout`=0 immediately; `in_ready`=1 after release. A fresh job returns the correct plaintext.
- Back-to-back with `out_ready`=1 and `in_valid`=1 continuously, using C.1 then App. B -> two correct outputs, acceptances 13 cycles apart.

Source files
------------

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher: one inverse round per clock, valid/ready on both sides.
// Also holds the shared GF(2^8) helpers, the key schedule and the per-column InvMixColumns lane.

package aes_dec_pkg;
    // multiply by x modulo 0x11b
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // inverse affine first, then field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < j; k++) r = xt(r);
        return r;
    endfunction
endpackage

// Key schedule; round key i at keys[128*(Nr-i) +: 128]
module KeyExpansion #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic [N-1:0]          key,
    output logic [128*(Nr+1)-1:0] keys
);
    import aes_dec_pkg::*;
    localparam int NW = 4 * (Nr + 1);

    for (genvar i = 0; i < NW; i++) begin : g_w
        logic [31:0] wd;
        if (i < Nk) begin : g_key
            assign wd = key[N-1-32*i -: 32];
        end else begin : g_exp
            logic [31:0] p;
            logic [31:0] t;
            assign p = g_w[i-1].wd;
            if (i % Nk == 0) begin : g_rot
                assign t = subword({p[23:0], p[31:24]}) ^ {rcon(i / Nk), 24'h000000};
            end else if (Nk > 6 && i % Nk == 4) begin : g_sub
                assign t = subword(p);
            end else begin : g_pass
                assign t = p;
            end
            assign wd = t ^ g_w[i-Nk].wd;
        end
    end

    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign keys[128*(Nr-r) +: 128] = {g_w[4*r].wd, g_w[4*r+1].wd, g_w[4*r+2].wd, g_w[4*r+3].wd};
    end
endmodule

// One column of InvMixColumns
module aes_inv_col (
    input  logic [31:0] c,
    output logic [31:0] m
);
    import aes_dec_pkg::*;
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = c;
    assign m = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
endmodule

module aes_decrypt #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] datain,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataout
);
    import aes_dec_pkg::*;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    state_t                  state;
    logic [127:0]            ct_reg;
    logic [N-1:0]            key_reg;
    logic [127:0]            st;
    logic [3:0]              rnd;
    logic [128*(Nr+1)-1:0]   keys;
    logic [127:0]            rk [Nr+1];
    logic [127:0]            sr_sb;
    logic [127:0]            ark;
    logic [127:0]            mixed;

    // schedule only sees the latched key, so round keys hold for the whole job
    KeyExpansion #(.N(N), .Nr(Nr), .Nk(Nk)) u_kexp (.key(key_reg), .keys(keys));

    for (genvar g = 0; g <= Nr; g++) begin : g_rk
        assign rk[g] = keys[128*(Nr-g) +: 128];
    end

    // InvShiftRows (row r rotated right by r) fused with InvSubBytes
    always_comb begin
        sr_sb = '0;
        for (int i = 0; i < 16; i++) begin
            sr_sb[127-8*i -: 8] = inv_sbox(st[127-8*(4*(((i/4) - (i%4) + 4) % 4) + (i%4)) -: 8]);
        end
    end

    assign ark = sr_sb ^ rk[rnd];

    for (genvar g = 0; g < 4; g++) begin : g_col
        aes_inv_col u_col (.c(ark[127-32*g -: 32]), .m(mixed[127-32*g -: 32]));
    end

    assign in_ready = (state == IDLE);

    // job sequencing, round state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ct_reg    <= '0;
            key_reg   <= '0;
            st        <= '0;
            rnd       <= '0;
            out_valid <= 1'b0;
            dataout   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ct_reg  <= datain;
                        key_reg <= key;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    st    <= ct_reg ^ rk[Nr];
                    rnd   <= 4'(Nr - 1);
                    state <= ROUND;
                end
                ROUND: begin
                    st <= mixed;
                    if (rnd == 4'd1) state <= FINAL;
                    else rnd <= rnd - 4'd1;
                end
                FINAL: begin
                    dataout   <= sr_sb ^ rk[0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // a same-cycle in_valid is not taken here; IDLE accepts it next cycle
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 vectors at all three key sizes plus handshake corners.
module tb_aes_decrypt;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] datain;
    logic         out_ready;
    logic [2:0]   vld;
    logic [2:0]   rdy;
    logic [2:0]   ovld;
    logic [127:0] dout [3];
    logic [127:0] k128;
    logic [191:0] k192;
    logic [255:0] k256;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KC  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_decrypt #(.N(128), .Nr(10), .Nk(4)) u128 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]), .datain(datain),
        .key(k128), .out_valid(ovld[0]), .out_ready(out_ready), .dataout(dout[0]));
    aes_decrypt #(.N(192), .Nr(12), .Nk(6)) u192 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]), .datain(datain),
        .key(k192), .out_valid(ovld[1]), .out_ready(out_ready), .dataout(dout[1]));
    aes_decrypt #(.N(256), .Nr(14), .Nk(8)) u256 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]), .datain(datain),
        .key(k256), .out_valid(ovld[2]), .out_ready(out_ready), .dataout(dout[2]));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_key(input int w, input logic [255:0] k);
        case (w)
            0:       k128 = k[127:0];
            1:       k192 = k[191:0];
            default: k256 = k;
        endcase
    endtask

    // accept one block on lane w, return cycles from acceptance edge to out_valid
    task automatic job(input int w, input logic [255:0] k, input logic [127:0] ct,
                       input bit scramble, output int lat);
        @(negedge clk);
        chk("in_ready_idle", 128'(rdy[w]), 128'd1);
        datain = ct;
        set_key(w, k);
        vld[w] = 1'b1;
        @(negedge clk);
        vld[w] = 1'b0;
        chk("in_ready_busy", 128'(rdy[w]), 128'd0);
        lat = 0;
        while (!ovld[w] && lat < 40) begin
            if (scramble) begin
                datain = {$urandom, $urandom, $urandom, $urandom};
                k128   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int acc [2];
        int na;
        int no;
        bit seen;
        logic [127:0] outs [2];

        vld = '0; out_ready = 1'b1; datain = '0;
        k128 = '0; k192 = '0; k256 = '0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int w = 0; w < 3; w++) begin
            chk("rst_in_ready", 128'(rdy[w]), 128'd1);
            chk("rst_out_valid", 128'(ovld[w]), 128'd0);
            chk("rst_dataout", dout[w], 128'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // App. B
        job(0, 256'(KB), CB, 1'b0, lat);
        chk("appb_lat", 128'(lat), 128'd11);
        chk("appb_pt", dout[0], PB);

        // App. C at each key size
        job(0, KC[255:128], C1, 1'b0, lat);
        chk("c1_lat", 128'(lat), 128'd11);
        chk("c1_pt", dout[0], PC);
        job(1, KC[255:64], C2, 1'b0, lat);
        chk("c2_lat", 128'(lat), 128'd13);
        chk("c2_pt", dout[1], PC);
        job(2, KC, C3, 1'b0, lat);
        chk("c3_lat", 128'(lat), 128'd15);
        chk("c3_pt", dout[2], PC);

        // backpressure: output held, in_valid pulses ignored
        @(negedge clk);
        out_ready = 1'b0;
        job(0, 256'(KB), CB, 1'b0, lat);
        chk("bp_lat", 128'(lat), 128'd11);
        for (int i = 0; i < 20; i++) begin
            vld[0] = i[0];
            datain = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_valid", 128'(ovld[0]), 128'd1);
            chk("bp_data", dout[0], PB);
            chk("bp_in_ready", 128'(rdy[0]), 128'd0);
        end
        vld[0] = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_retired", 128'(ovld[0]), 128'd0);
        chk("bp_ready_back", 128'(rdy[0]), 128'd1);

        // inputs scrambled every cycle of the job
        job(0, 256'(KB), CB, 1'b1, lat);
        chk("scr_lat", 128'(lat), 128'd11);
        chk("scr_pt", dout[0], PB);

        // reset at cycle 5 of a job; dataout still holds the previous plaintext
        @(negedge clk);
        datain = CB; k128 = KB; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(ovld[0]), 128'd0);
        chk("mid_rst_data", dout[0], 128'd0);
        chk("mid_rst_ready", 128'(rdy[0]), 128'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ovld[0]) seen = 1'b1;
        end
        chk("abort_no_valid", 128'(seen), 128'd0);
        job(0, 256'(KB), CB, 1'b0, lat);
        chk("post_rst_lat", 128'(lat), 128'd11);
        chk("post_rst_pt", dout[0], PB);

        // back-to-back, in_valid and out_ready held high
        @(negedge clk);
        datain = C1; k128 = KC[255:128]; vld[0] = 1'b1;
        na = 0; no = 0; acc[0] = 0; acc[1] = 0; outs[0] = '0; outs[1] = '0;
        for (int c = 0; c < 40; c++) begin
            if (ovld[0] && no < 2) begin outs[no] = dout[0]; no++; end
            if (vld[0] && rdy[0] && na < 2) begin acc[na] = c; na++; end
            @(negedge clk);
            if (na == 1) begin datain = CB; k128 = KB; end
        end
        vld[0] = 1'b0;
        chk("b2b_accepts", 128'(na), 128'd2);
        chk("b2b_outs", 128'(no), 128'd2);
        chk("b2b_spacing", 128'(acc[1] - acc[0]), 128'd13);
        chk("b2b_pt0", outs[0], PC);
        chk("b2b_pt1", outs[1], PB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
